// File: rtl/exec_pkg.sv
// Shared definitions for the registered execute unit: op encodings,
// the op type and the divider FSM state type.
package exec_pkg;

    typedef logic [5:0] op_t;

    typedef enum logic {
        IDLE = 1'b0,
        DIV  = 1'b1
    } state_t;

    // Base ALU group (op[5]=0, op[4]=0), op[3:0]
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SLL  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_SUB  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd13;

    // Branch / JALR / LUI group (op[5]=0, op[4]=1), op[3:0]
    localparam logic [3:0] BR_BEQ  = 4'd0;
    localparam logic [3:0] BR_BNE  = 4'd1;
    localparam logic [3:0] BR_BLT  = 4'd4;
    localparam logic [3:0] BR_BGE  = 4'd5;
    localparam logic [3:0] BR_BLTU = 4'd6;
    localparam logic [3:0] BR_BGEU = 4'd7;
    localparam logic [3:0] BR_LUI  = 4'd8;
    localparam logic [3:0] BR_JALR = 4'd9;

    // M-extension group (op[5]=1), op[2:0] = funct3
    localparam logic [2:0] M_MUL    = 3'd0;
    localparam logic [2:0] M_MULH   = 3'd1;
    localparam logic [2:0] M_MULHSU = 3'd2;
    localparam logic [2:0] M_MULHU  = 3'd3;
    localparam logic [2:0] M_DIV    = 3'd4;
    localparam logic [2:0] M_DIVU   = 3'd5;
    localparam logic [2:0] M_REM    = 3'd6;
    localparam logic [2:0] M_REMU   = 3'd7;

    // True for DIV/DIVU/REM/REMU
    function automatic logic is_div_op(input op_t op);
        return op[5] & op[2];
    endfunction

endpackage

// File: rtl/exec_unit_pipe_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU. Divide-by-zero and
// signed overflow are flagged combinationally so the caller can finish
// them in one cycle without starting the FSM. done is asserted during the
// last iteration together with the sign-corrected result.
module exec_divider
    import exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            special,
    output logic [XLEN-1:0] special_result,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] dvs_r;
    logic            q_neg_r;
    logic            r_neg_r;
    logic            rem_sel_r;

    logic            signed_s;
    logic            div_zero_s;
    logic            overflow_s;
    logic [XLEN:0]   shifted_s;
    logic [XLEN:0]   diff_s;
    logic [XLEN-1:0] quo_nxt_s;
    logic [XLEN-1:0] rem_nxt_s;

    assign signed_s   = ~funct3[0];
    assign div_zero_s = (divisor == {XLEN{1'b0}});
    assign overflow_s = signed_s && (dividend == MIN_VAL) && (divisor == {XLEN{1'b1}});
    assign special    = div_zero_s || overflow_s;
    assign busy       = (state_r == DIV);
    assign done       = (state_r == DIV) && (cnt_r == CNT_LAST);

    // Special-case results: x/0 and MIN/-1
    always_comb begin
        special_result = {XLEN{1'b0}};
        if (div_zero_s) begin
            special_result = funct3[1] ? dividend : {XLEN{1'b1}};
        end else if (overflow_s) begin
            special_result = funct3[1] ? {XLEN{1'b0}} : MIN_VAL;
        end else begin
            special_result = {XLEN{1'b0}};
        end
    end

    // One restoring shift-subtract step plus final sign correction
    always_comb begin
        shifted_s = {rem_r, quo_r[XLEN-1]};
        diff_s    = shifted_s - {1'b0, dvs_r};
        if (!diff_s[XLEN]) begin
            rem_nxt_s = diff_s[XLEN-1:0];
            quo_nxt_s = {quo_r[XLEN-2:0], 1'b1};
        end else begin
            rem_nxt_s = shifted_s[XLEN-1:0];
            quo_nxt_s = {quo_r[XLEN-2:0], 1'b0};
        end
        if (rem_sel_r) begin
            result = r_neg_r ? -rem_nxt_s : rem_nxt_s;
        end else begin
            result = q_neg_r ? -quo_nxt_s : quo_nxt_s;
        end
    end

    // Divider FSM: latch magnitudes on start, iterate XLEN times
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            quo_r     <= {XLEN{1'b0}};
            rem_r     <= {XLEN{1'b0}};
            dvs_r     <= {XLEN{1'b0}};
            q_neg_r   <= 1'b0;
            r_neg_r   <= 1'b0;
            rem_sel_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        quo_r     <= (signed_s && dividend[XLEN-1]) ? -dividend : dividend;
                        dvs_r     <= (signed_s && divisor[XLEN-1]) ? -divisor : divisor;
                        rem_r     <= {XLEN{1'b0}};
                        q_neg_r   <= signed_s && (dividend[XLEN-1] ^ divisor[XLEN-1]);
                        r_neg_r   <= signed_s && dividend[XLEN-1];
                        rem_sel_r <= funct3[1];
                        cnt_r     <= CNT_INIT;
                        state_r   <= DIV;
                    end
                end
                DIV: begin
                    quo_r <= quo_nxt_s;
                    rem_r <= rem_nxt_s;
                    cnt_r <= cnt_r - CNT_LAST;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/exec_unit_pipe.sv
// Registered execute unit: RV32I-style ALU, branch compare, JALR and LUI
// behind a valid/ready handshake. Define EXEC_MULDIV_EN to build the
// single-cycle multiplier and the iterative divider; otherwise every
// M-extension op completes in one cycle as an illegal op.
module exec_unit_pipe
    import exec_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      operation,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_bcond,
    output logic            illegal_op,
    output logic            busy
);

    op_t             op_s;
    logic [SHW-1:0]  shamt_s;
    logic            accept_s;
    logic            div_start_s;
    logic            div_done_s;
    logic [XLEN-1:0] div_result_s;
    logic [XLEN-1:0] res_s;
    logic            bcond_s;
    logic            ill_s;

    assign op_s     = operation;
    assign shamt_s  = operand2[SHW-1:0];
    assign accept_s = in_valid && in_ready;
    assign in_ready = !busy && (!out_valid || out_ready);

`ifdef EXEC_MULDIV_EN
    logic            div_special_s;
    logic [XLEN-1:0] div_special_res_s;
    logic [2*XLEN-1:0] ma_s;
    logic [2*XLEN-1:0] mb_s;
    logic [2*XLEN-1:0] prod_s;

    assign div_start_s = accept_s && is_div_op(op_s) && !div_special_s;

    exec_divider #(.XLEN(XLEN)) u_div (
        .clk            (clk),
        .rst            (rst),
        .start          (div_start_s),
        .funct3         (op_s[2:0]),
        .dividend       (operand1),
        .divisor        (operand2),
        .special        (div_special_s),
        .special_result (div_special_res_s),
        .done           (div_done_s),
        .result         (div_result_s),
        .busy           (busy)
    );

    // Sign/zero-extend operands to 2*XLEN so one multiplier serves all MUL ops
    always_comb begin
        if ((op_s[1:0] == 2'b01) || (op_s[1:0] == 2'b10)) begin
            ma_s = {{XLEN{operand1[XLEN-1]}}, operand1};
        end else begin
            ma_s = {{XLEN{1'b0}}, operand1};
        end
        if (op_s[1:0] == 2'b01) begin
            mb_s = {{XLEN{operand2[XLEN-1]}}, operand2};
        end else begin
            mb_s = {{XLEN{1'b0}}, operand2};
        end
        prod_s = ma_s * mb_s;
    end
`else
    assign div_start_s  = 1'b0;
    assign div_done_s   = 1'b0;
    assign div_result_s = {XLEN{1'b0}};
    assign busy         = 1'b0;
`endif

    // Next result for every op that completes in a single cycle
    always_comb begin
        res_s   = {XLEN{1'b0}};
        bcond_s = 1'b0;
        ill_s   = 1'b0;
        if (!op_s[5]) begin
            if (!op_s[4]) begin
                case (op_s[3:0])
                    ALU_ADD:  res_s = operand1 + operand2;
                    ALU_SUB:  res_s = operand1 - operand2;
                    ALU_XOR:  res_s = operand1 ^ operand2;
                    ALU_OR:   res_s = operand1 | operand2;
                    ALU_AND:  res_s = operand1 & operand2;
                    ALU_SLT:  res_s = {{(XLEN-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
                    ALU_SLTU: res_s = {{(XLEN-1){1'b0}}, (operand1 < operand2)};
                    ALU_SLL:  res_s = operand1 << shamt_s;
                    ALU_SRL:  res_s = operand1 >> shamt_s;
                    ALU_SRA:  res_s = $unsigned($signed(operand1) >>> shamt_s);
                    default:  ill_s = 1'b1;
                endcase
            end else begin
                case (op_s[3:0])
                    BR_BEQ:  bcond_s = (operand1 == operand2);
                    BR_BNE:  bcond_s = (operand1 != operand2);
                    BR_BLT:  bcond_s = ($signed(operand1) < $signed(operand2));
                    BR_BGE:  bcond_s = ($signed(operand1) >= $signed(operand2));
                    BR_BLTU: bcond_s = (operand1 < operand2);
                    BR_BGEU: bcond_s = (operand1 >= operand2);
                    BR_LUI:  res_s   = operand2;
                    BR_JALR: res_s   = (operand1 + operand2) & {{(XLEN-1){1'b1}}, 1'b0};
                    default: ill_s   = 1'b1;
                endcase
            end
        end else begin
`ifdef EXEC_MULDIV_EN
            case (op_s[2:0])
                M_MUL:    res_s = prod_s[XLEN-1:0];
                M_MULH,
                M_MULHSU,
                M_MULHU:  res_s = prod_s[2*XLEN-1:XLEN];
                default:  res_s = div_special_res_s;
            endcase
`else
            ill_s = 1'b1;
`endif
        end
    end

    // Output register: divider completion, single-cycle load, or drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= {XLEN{1'b0}};
            out_bcond  <= 1'b0;
            illegal_op <= 1'b0;
        end else if (div_done_s) begin
            out_valid  <= 1'b1;
            out_result <= div_result_s;
            out_bcond  <= 1'b0;
            illegal_op <= 1'b0;
        end else if (accept_s && !div_start_s) begin
            out_valid  <= 1'b1;
            out_result <= res_s;
            out_bcond  <= bcond_s;
            illegal_op <= ill_s;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end else begin
            out_valid  <= out_valid;
        end
    end

endmodule

// File: tb/tb_exec_unit_pipe.sv
// Self-checking bench for exec_unit_pipe (XLEN=32). Table-driven
// single-cycle vectors plus hand-written backpressure, divider and
// reset-abort sequences. Divider/multiplier sequences follow EXEC_MULDIV_EN.
module tb_exec_unit_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  operation;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_bcond;
    logic        illegal_op;
    logic        busy;

    int checks;
    int errors;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        bc;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    exec_unit_pipe #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .operation  (operation),
        .operand1   (operand1),
        .operand2   (operand2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_bcond  (out_bcond),
        .illegal_op (illegal_op),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present an op at a negedge and hold it until the accepting posedge
    task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        operation = op;
        operand1  = a;
        operand2  = b;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout: got in_ready %b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count negedges after the accept edge until out_valid is seen
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
    endtask

    initial begin
        int lat;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        operation = 6'd0;
        operand1  = 32'd0;
        operand2  = 32'd0;
        out_ready = 1'b1;

        // op, a, b, result, bcond, illegal
        vecs.push_back('{6'h00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0});
        vecs.push_back('{6'h08, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0});
        vecs.push_back('{6'h04, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0, 1'b0});
        vecs.push_back('{6'h03, 32'h00000F00, 32'h000000F0, 32'h00000FF0, 1'b0, 1'b0});
        vecs.push_back('{6'h07, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0, 1'b0});
        vecs.push_back('{6'h02, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0});
        vecs.push_back('{6'h06, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{6'h01, 32'h00000001, 32'h00000021, 32'h00000002, 1'b0, 1'b0});
        vecs.push_back('{6'h05, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0});
        vecs.push_back('{6'h0D, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1'b0});
        vecs.push_back('{6'h10, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{6'h11, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{6'h14, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{6'h15, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{6'h16, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{6'h17, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{6'h18, 32'h00000123, 32'h12345000, 32'h12345000, 1'b0, 1'b0});
        vecs.push_back('{6'h19, 32'h00001001, 32'h00000002, 32'h00001002, 1'b0, 1'b0});
        vecs.push_back('{6'h0F, 32'h12345678, 32'h00000001, 32'h00000000, 1'b0, 1'b1});
        vecs.push_back('{6'h1A, 32'h00000001, 32'h00000001, 32'h00000000, 1'b0, 1'b1});
`ifdef EXEC_MULDIV_EN
        vecs.push_back('{6'h20, 32'h00000003, 32'h00000004, 32'h0000000C, 1'b0, 1'b0});
        vecs.push_back('{6'h20, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0});
        vecs.push_back('{6'h21, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{6'h22, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0});
        vecs.push_back('{6'h23, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0});
`else
        vecs.push_back('{6'h20, 32'h00000003, 32'h00000004, 32'h00000000, 1'b0, 1'b1});
        vecs.push_back('{6'h24, 32'h00000007, 32'h00000002, 32'h00000000, 1'b0, 1'b1});
`endif

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_bcond", {31'd0, out_bcond}, 32'd0);
        chk("rst_illegal", {31'd0, illegal_op}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;

        // Table-driven single-cycle ops
        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_result(lat);
            chk($sformatf("vec%0d_latency", i), lat, 32'd1);
            chk($sformatf("vec%0d_result", i), out_result, vecs[i].res);
            chk($sformatf("vec%0d_bcond", i), {31'd0, out_bcond}, {31'd0, vecs[i].bc});
            chk($sformatf("vec%0d_illegal", i), {31'd0, illegal_op}, {31'd0, vecs[i].ill});
        end
        @(negedge clk);
        chk("drain_out_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: result held while out_ready=0, then drain+accept in one cycle
        out_ready = 1'b0;
        send(6'h00, 32'd1, 32'd2);
        wait_result(lat);
        chk("bp_latency", lat, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_result", out_result, 32'd3);
        end
        in_valid  = 1'b1;
        operation = 6'h08;
        operand1  = 32'd10;
        operand2  = 32'd3;
        out_ready = 1'b1;
        #1;
        chk("bp_same_cycle_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_next_result", out_result, 32'd7);
        @(negedge clk);
        chk("bp_clear_valid", {31'd0, out_valid}, 32'd0);

`ifdef EXEC_MULDIV_EN
        // DIV -7/2 -> -3 after XLEN+1 cycles, busy and in_ready=0 meanwhile
        send(6'h24, 32'hFFFFFFF9, 32'd2);
        @(negedge clk);
        chk("div_busy", {31'd0, busy}, 32'd1);
        chk("div_in_ready", {31'd0, in_ready}, 32'd0);
        wait_result(lat);
        chk("div_latency", lat + 1, 32'd33);
        chk("div_result", out_result, 32'hFFFFFFFD);
        chk("div_illegal", {31'd0, illegal_op}, 32'd0);
        send(6'h26, 32'hFFFFFFF9, 32'd2);
        wait_result(lat);
        chk("rem_latency", lat, 32'd33);
        chk("rem_result", out_result, 32'hFFFFFFFF);
        send(6'h25, 32'd100, 32'd7);
        wait_result(lat);
        chk("divu_result", out_result, 32'd14);
        send(6'h27, 32'd100, 32'd7);
        wait_result(lat);
        chk("remu_result", out_result, 32'd2);
        send(6'h25, 32'd5, 32'd0);
        wait_result(lat);
        chk("divu0_latency", lat, 32'd1);
        chk("divu0_result", out_result, 32'hFFFFFFFF);
        send(6'h26, 32'hFFFFFFF9, 32'd0);
        wait_result(lat);
        chk("rem0_result", out_result, 32'hFFFFFFF9);
        send(6'h24, 32'h80000000, 32'hFFFFFFFF);
        wait_result(lat);
        chk("ovf_latency", lat, 32'd1);
        chk("ovf_result", out_result, 32'h80000000);
        send(6'h26, 32'h80000000, 32'hFFFFFFFF);
        wait_result(lat);
        chk("ovf_rem_result", out_result, 32'd0);

        // Reset in the middle of a divide aborts it
        send(6'h24, 32'd100, 32'd3);
        repeat (10) @(negedge clk);
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (40) @(negedge clk);
        chk("abort_no_result", {31'd0, out_valid}, 32'd0);
`else
        // Without the M unit a would-be divide never goes busy
        send(6'h24, 32'd100, 32'd3);
        @(negedge clk);
        chk("nomd_busy", {31'd0, busy}, 32'd0);
        chk("nomd_in_ready", {31'd0, in_ready}, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
